// File: rtl/aurora_axis_traffic_gen.sv
// Loopback traffic source and checker for the Aurora streaming kernel.
// Drives a counting pattern into tx_axis and checks rx_axis beats against it.
module aurora_axis_traffic_gen #(
  parameter int unsigned TIMEOUT_W = 32,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     frame_len,
  input  logic [31:0]          seed,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 tx_axis_tvalid,
  output logic [255:0]         tx_axis_tdata,
  input  logic                 tx_axis_tready,
  input  logic                 rx_axis_tvalid,
  input  logic [255:0]         rx_axis_tdata,
  output logic                 rx_axis_tready,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     tx_count,
  output logic [CNT_W-1:0]     rx_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [15:0]          stray_count
);

  localparam int unsigned DATA_W = 256;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned WORDS  = DATA_W / WORD_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q;
  state_t               state_nxt;
  logic [CNT_W-1:0]     len_q;
  logic [WORD_W-1:0]    tx_base_q;
  logic [WORD_W-1:0]    rx_base_q;
  logic [TIMEOUT_W-1:0] idle_q;

  logic start_acc_c;
  logic tmo_hit_c;
  logic tx_acc_c;
  logic rx_beat_c;
  logic rx_live_c;

  // Word k of a beat is base + k; base advances by WORDS per beat.
  function automatic logic [DATA_W-1:0] beat_pattern(input logic [WORD_W-1:0] base);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      p[WORD_W*k +: WORD_W] = base + WORD_W'(k);
    end
    return p;
  endfunction

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decode; timeout fires on the cycle the idle count reaches the limit.
  always_comb begin
    state_nxt   = state_q;
    start_acc_c = 1'b0;
    tmo_hit_c   = 1'b0;
    tx_acc_c    = tx_axis_tvalid && tx_axis_tready;
    rx_beat_c   = rx_axis_tvalid && rx_axis_tready;
    rx_live_c   = (state_q == S_RUN) && (rx_count < len_q);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_acc_c = 1'b1;
          state_nxt   = (frame_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if ((tx_count == len_q) && (rx_count == len_q)) begin
          state_nxt = S_DONE;
        end else if ((timeout_limit != '0) && !rx_beat_c &&
                     ((idle_q + TIMEOUT_W'(1)) == timeout_limit)) begin
          state_nxt = S_DONE;
          tmo_hit_c = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tdata  <= '0;
      rx_axis_tready <= 1'b1;
      tx_count       <= '0;
      rx_count       <= '0;
      err_count      <= '0;
      first_err_idx  <= '1;
      stray_count    <= '0;
      len_q          <= '0;
      tx_base_q      <= '0;
      rx_base_q      <= '0;
      idle_q         <= '0;
    end else begin
      busy           <= (state_nxt == S_RUN);
      done           <= (state_nxt == S_DONE);
      rx_axis_tready <= 1'b1;

      if (start_acc_c) begin
        len_q          <= frame_len;
        tx_base_q      <= seed;
        rx_base_q      <= seed;
        tx_count       <= '0;
        rx_count       <= '0;
        err_count      <= '0;
        first_err_idx  <= '1;
        timeout        <= 1'b0;
        idle_q         <= '0;
        tx_axis_tvalid <= (frame_len != '0);
        tx_axis_tdata  <= beat_pattern(seed);
      end else if (state_q == S_RUN) begin
        if (tx_acc_c) begin
          tx_count  <= tx_count + CNT_W'(1);
          tx_base_q <= tx_base_q + WORD_W'(WORDS);
          if ((tx_count + CNT_W'(1)) == len_q) begin
            tx_axis_tvalid <= 1'b0;
          end else begin
            tx_axis_tdata <= beat_pattern(tx_base_q + WORD_W'(WORDS));
          end
        end

        if (rx_beat_c && rx_live_c) begin
          rx_count  <= rx_count + CNT_W'(1);
          rx_base_q <= rx_base_q + WORD_W'(WORDS);
          if (rx_axis_tdata != beat_pattern(rx_base_q)) begin
            if (err_count != '1) begin
              err_count <= err_count + CNT_W'(1);
            end
            if (first_err_idx == '1) begin
              first_err_idx <= rx_count;
            end
          end
        end

        idle_q <= rx_beat_c ? '0 : idle_q + TIMEOUT_W'(1);

        if (tmo_hit_c) begin
          timeout        <= 1'b1;
          tx_axis_tvalid <= 1'b0;
        end
      end

      // Beats outside an open RUN window are only counted, never checked.
      if (rx_beat_c && !rx_live_c && (stray_count != 16'hFFFF)) begin
        stray_count <= stray_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_aurora_axis_traffic_gen.sv
// Directed bench for aurora_axis_traffic_gen: table of loopback/timeout runs
// plus hand sequences for zero-length, ignored start, stray beats and reset.
module tb_aurora_axis_traffic_gen;

  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic         start;
  logic [31:0]  frame_len;
  logic [31:0]  seed;
  logic [31:0]  timeout_limit;
  logic         tx_axis_tvalid;
  logic [255:0] tx_axis_tdata;
  logic         tx_axis_tready;
  logic         rx_axis_tvalid;
  logic [255:0] rx_axis_tdata;
  logic         rx_axis_tready;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [31:0]  tx_count;
  logic [31:0]  rx_count;
  logic [31:0]  err_count;
  logic [31:0]  first_err_idx;
  logic [15:0]  stray_count;

  int           tests = 0;
  int           fails = 0;
  logic         loop_en;
  logic         rx_v_drv;
  int           flip_idx;
  int           mon_idx;
  logic         start_real;
  logic [31:0]  cur_seed;
  logic         prev_stall;
  logic [255:0] prev_data;

  typedef struct {
    logic [31:0] seed;
    logic [31:0] len;
    logic [31:0] tmo;
    bit          loop;
    bit          toggle;
    int          flip;
    logic [31:0] exp_tx;
    logic [31:0] exp_rx;
    logic [31:0] exp_err;
    logic [31:0] exp_first;
    bit          exp_tmo;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[5];

  always #5 ap_clk = ~ap_clk;

  // Loopback wire with optional single-bit corruption of one beat.
  assign rx_axis_tvalid = loop_en ? (tx_axis_tvalid & tx_axis_tready) : rx_v_drv;
  assign rx_axis_tdata  = loop_en ? (tx_axis_tdata ^ ((flip_idx == mon_idx) ? 256'd1 : 256'd0))
                                  : 256'd0;

  aurora_axis_traffic_gen #(.TIMEOUT_W(32), .CNT_W(32)) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .start         (start),
    .frame_len     (frame_len),
    .seed          (seed),
    .timeout_limit (timeout_limit),
    .tx_axis_tvalid(tx_axis_tvalid),
    .tx_axis_tdata (tx_axis_tdata),
    .tx_axis_tready(tx_axis_tready),
    .rx_axis_tvalid(rx_axis_tvalid),
    .rx_axis_tdata (rx_axis_tdata),
    .rx_axis_tready(rx_axis_tready),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .tx_count      (tx_count),
    .rx_count      (rx_count),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .stray_count   (stray_count)
  );

  function automatic logic [255:0] pat(input logic [31:0] s, input int idx);
    logic [255:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) p[32*k +: 32] = s + 32'(8*idx + k);
    return p;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Index of the tx beat currently on the bus.
  always @(posedge ap_clk) begin
    if (ap_rst || (start && start_real)) mon_idx <= 0;
    else if (tx_axis_tvalid && tx_axis_tready) mon_idx <= mon_idx + 1;
  end

  // Every accepted beat must carry the expected pattern; stalled beats must hold.
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("tx_hold_valid", tx_axis_tvalid, 1);
        chk("tx_hold_data", tx_axis_tdata, prev_data);
      end
      if (tx_axis_tvalid && tx_axis_tready) chk("tx_beat_data", tx_axis_tdata, pat(cur_seed, mon_idx));
      prev_stall <= tx_axis_tvalid && !tx_axis_tready;
      prev_data  <= tx_axis_tdata;
    end
  end

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] len, input logic real_start);
    seed       = s;
    frame_len  = len;
    start_real = real_start;
    start      = 1'b1;
    @(posedge ap_clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, output int cycles);
    cycles = 0;
    while (!done && cycles < 200) begin
      @(posedge ap_clk); #1;
      cycles++;
      if (toggle) tx_axis_tready = ~tx_axis_tready;
    end
    chk("done", done, 1);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int cycles;
    timeout_limit  = v.tmo;
    loop_en        = v.loop;
    flip_idx       = v.flip;
    cur_seed       = v.seed;
    tx_axis_tready = 1'b1;
    pulse_start(v.seed, v.len, 1'b1);
    if (v.toggle) tx_axis_tready = ~tx_axis_tready;
    wait_done(v.toggle, cycles);
    chk($sformatf("v%0d_cycles", n), cycles, v.exp_cycles);
    chk($sformatf("v%0d_tx_count", n), tx_count, v.exp_tx);
    chk($sformatf("v%0d_rx_count", n), rx_count, v.exp_rx);
    chk($sformatf("v%0d_err_count", n), err_count, v.exp_err);
    chk($sformatf("v%0d_first_err", n), first_err_idx, v.exp_first);
    chk($sformatf("v%0d_timeout", n), timeout, v.exp_tmo);
    chk($sformatf("v%0d_busy", n), busy, 0);
    chk($sformatf("v%0d_tvalid", n), tx_axis_tvalid, 0);
  endtask

  initial begin
    int cycles;
    //          seed          len  tmo  loop tog flip  tx rx err first         tmo cyc
    vecs[0] = '{32'h100,      4,   0,   1,   0,  -1,   4, 4, 0, 32'hFFFFFFFF, 0,  5};
    vecs[1] = '{32'hFFFFFFF8, 3,   0,   1,   1,  -1,   3, 3, 0, 32'hFFFFFFFF, 0,  7};
    vecs[2] = '{32'h1000,     5,   0,   1,   0,   2,   5, 5, 1, 32'd2,        0,  6};
    vecs[3] = '{32'h0,        8,   16,  0,   0,  -1,   8, 0, 0, 32'hFFFFFFFF, 1,  16};
    vecs[4] = '{32'hABCD0000, 6,   0,   1,   0,   0,   6, 6, 1, 32'd0,        0,  7};

    ap_rst = 1'b1; start = 1'b0; frame_len = '0; seed = '0; timeout_limit = '0;
    tx_axis_tready = 1'b1; loop_en = 1'b0; rx_v_drv = 1'b0; flip_idx = -1;
    start_real = 1'b0; cur_seed = '0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;

    // Reset state
    chk("rst_tvalid", tx_axis_tvalid, 0);
    chk("rst_tdata", tx_axis_tdata, 0);
    chk("rst_rx_tready", rx_axis_tready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_first_err", first_err_idx, 32'hFFFFFFFF);
    chk("rst_stray", stray_count, 0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Zero-length frame goes straight to DONE
    loop_en = 1'b1; flip_idx = -1; timeout_limit = 0; tx_axis_tready = 1'b1;
    pulse_start(32'h77, 0, 1'b1);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_tvalid", tx_axis_tvalid, 0);
    repeat (2) @(posedge ap_clk);
    #1 chk("zero_tvalid_later", tx_axis_tvalid, 0);
    chk("zero_tx_count", tx_count, 0);

    // Start during RUN is ignored: seed and length stay from the first start
    tx_axis_tready = 1'b0; cur_seed = 32'h55;
    pulse_start(32'h55, 6, 1'b1);
    repeat (2) @(posedge ap_clk);
    #1 chk("ign_busy", busy, 1);
    pulse_start(32'h999, 2, 1'b0);
    chk("ign_busy_after", busy, 1);
    chk("ign_tx_count", tx_count, 0);
    tx_axis_tready = 1'b1;
    wait_done(1'b0, cycles);
    chk("ign_tx_final", tx_count, 6);
    chk("ign_rx_final", rx_count, 6);
    chk("ign_err", err_count, 0);

    // Stray beats while DONE, then reset mid-RUN
    loop_en = 1'b0; rx_v_drv = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1 rx_v_drv = 1'b0;
    chk("stray_count", stray_count, 3);
    chk("stray_rx_count", rx_count, 6);
    tx_axis_tready = 1'b0;
    pulse_start(32'h10, 8, 1'b1);
    repeat (3) @(posedge ap_clk);
    #1 chk("mid_busy", busy, 1);
    chk("mid_tvalid", tx_axis_tvalid, 1);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_tvalid", tx_axis_tvalid, 0);
    chk("mrst_tdata", tx_axis_tdata, 0);
    chk("mrst_tx_count", tx_count, 0);
    chk("mrst_rx_count", rx_count, 0);
    chk("mrst_err", err_count, 0);
    chk("mrst_first_err", first_err_idx, 32'hFFFFFFFF);
    chk("mrst_stray", stray_count, 0);
    repeat (2) @(posedge ap_clk);
    #1 chk("mrst_idle_stays", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
